voice_allocator: RTL and testbench
==================================

// Module: voice_allocator
// PURPOSE
//   Polyphonic voice scheduler for the square-wave oscillator bank. Accepts key
//   note-on/note-off events and assigns each note to one of NUM_VOICES oscillators.
//   Drives each oscillator's period and load-enable, aligned to AC'97 frame boundaries.
//   Sits between the key/MIDI decoder and the oscillator bank; VOICE_ACTIVE gates the mixer.
// PARAMETERS
//   NUM_VOICES  4   number of oscillator voices managed (2..8)
//   PERIOD_W    7   width of a period value, in frames
//   RST_PERIOD  48  period driven on every voice after reset
// PORTS
//   BIT_CLK       in   1              AC'97 bit clock; all logic on posedge
//   RESET         in   1              synchronous, active-high reset
//   frame_sig     in   1              one-cycle pulse per AC'97 frame
//   KEY_VALID     in   1              key event valid
//   KEY_READY     out  1              allocator can accept an event
//   KEY_ON        in   1              1 = note-on, 0 = note-off
//   KEY_PERIOD    in   PERIOD_W       note period; also serves as note identity
//   VOICE_PERIOD  out  NUM_VOICES*PERIOD_W  per-voice period, voice i at [i*PERIOD_W +: PERIOD_W]
//   VOICE_EN      out  NUM_VOICES     one-cycle load pulse to oscillator i's en
//   VOICE_ACTIVE  out  NUM_VOICES     voice i currently sounding
//   STOLE         out  1              one-cycle pulse when an active voice is stolen
// BEHAVIOUR
//   Reset: VOICE_PERIOD = RST_PERIOD on all voices; VOICE_EN = 0; VOICE_ACTIVE = 0; STOLE = 0.
//     KEY_READY = 0 while RESET is high. FSM returns to IDLE.
//     LRU rank of voice i = i, so voice NUM_VOICES-1 is the oldest.
//   FSM: IDLE -> LOOKUP -> WAIT_FRAME -> APPLY -> IDLE.
//   IDLE: KEY_READY = 1. A transfer occurs when KEY_VALID && KEY_READY.
//     On transfer, KEY_ON and KEY_PERIOD are captured and the FSM goes to LOOKUP.
//     KEY_READY = 0 in every other state.
//   LOOKUP (1 cycle): select the target voice.
//     note-on, KEY_PERIOD == 0: event dropped -> IDLE.
//     note-on matching an active voice's period: retrigger that voice (lowest index on tie).
//     note-on, otherwise: lowest-index inactive voice.
//     note-on, all voices active: steal the voice with LRU rank NUM_VOICES-1.
//     note-off: lowest-index active voice whose period matches; if none, drop -> IDLE.
//     Otherwise -> WAIT_FRAME.
//   WAIT_FRAME: hold until a cycle with frame_sig = 1, then -> APPLY on the next edge.
//     A frame_sig in LOOKUP is ignored; the FSM waits for the next one.
//   APPLY (1 cycle), note-on:
//     VOICE_PERIOD[v] <= captured period; VOICE_EN[v] = 1 for exactly this cycle.
//     VOICE_ACTIVE[v] <= 1. STOLE = 1 if v was stolen.
//     LRU update: voices with rank < rank[v] increment; rank[v] <= 0.
//   APPLY (1 cycle), note-off:
//     VOICE_ACTIVE[v] <= 0. No VOICE_EN pulse; VOICE_PERIOD and ranks unchanged.
//   Ranks always form a permutation of 0..NUM_VOICES-1, width $clog2(NUM_VOICES).
//   Latency: accept-to-EN = 2 cycles + the wait for frame_sig.
//     Minimum 3 cycles, when frame_sig arrives on the first WAIT_FRAME cycle.
//   At most one VOICE_EN bit is high in any cycle. Events are processed strictly in order.
//   RESET in any state aborts the pending event; no VOICE_EN or STOLE is emitted.
// TESTING
//   1. Hold RESET 3 cycles, release.
//      -> VOICE_ACTIVE = 0, all VOICE_PERIOD = 48, KEY_READY = 1 on the 1st cycle after release.
//   2. Note-on 40; frame_sig on the 1st WAIT_FRAME cycle.
//      -> VOICE_EN = 0001 for one cycle, 3 cycles after accept; VOICE_PERIOD[0] = 40; ACTIVE = 0001.
//   3. Note-on 40, 30, 20, 10, then 50.
//      -> 5th event steals voice 0: VOICE_PERIOD[0] = 50, STOLE pulses once, ACTIVE = 1111.
//   4. Note-off 30, then note-off 99.
//      -> ACTIVE bit 1 clears with no VOICE_EN; the 99 event drops with no output change,
//         and KEY_READY returns 2 cycles after accept.
//   5. With 4 voices full, retrigger 40 (voice 0), then note-on 60.
//      -> 60 steals voice 1 (next-oldest), not voice 0.
//   6. Accept note-on 25, assert RESET during WAIT_FRAME.
//      -> no VOICE_EN pulse; all outputs return to reset values.

Source files
------------

// File: rtl/voice_allocator.sv
// rtl/voice_allocator.sv - polyphonic voice scheduler for the square-wave oscillator bank
//
// Takes note-on/note-off key events and assigns each note to one of NUM_VOICES
// oscillators. Period loads are applied only on AC'97 frame boundaries.
//
// Ports:
//   BIT_CLK       in   AC'97 bit clock; all logic on posedge
//   RESET         in   synchronous active-high reset
//   frame_sig     in   one-cycle pulse per AC'97 frame
//   KEY_VALID     in   key event valid
//   KEY_READY     out  allocator can accept an event (IDLE only)
//   KEY_ON        in   1 = note-on, 0 = note-off
//   KEY_PERIOD    in   note period; also the note identity
//   VOICE_PERIOD  out  per-voice period, voice i at [i*PERIOD_W +: PERIOD_W]
//   VOICE_EN      out  one-cycle load pulse to oscillator i
//   VOICE_ACTIVE  out  voice i currently sounding
//   STOLE         out  one-cycle pulse when an active voice is reassigned
module voice_allocator #(
    parameter int NUM_VOICES = 4,
    parameter int PERIOD_W   = 7,
    parameter int RST_PERIOD = 48
) (
    input  logic                           BIT_CLK,
    input  logic                           RESET,
    input  logic                           frame_sig,
    input  logic                           KEY_VALID,
    output logic                           KEY_READY,
    input  logic                           KEY_ON,
    input  logic [PERIOD_W-1:0]            KEY_PERIOD,
    output logic [NUM_VOICES*PERIOD_W-1:0] VOICE_PERIOD,
    output logic [NUM_VOICES-1:0]          VOICE_EN,
    output logic [NUM_VOICES-1:0]          VOICE_ACTIVE,
    output logic                           STOLE
);

    localparam int IDX_W = $clog2(NUM_VOICES);
    localparam logic [IDX_W-1:0] OLDEST_RANK = IDX_W'(NUM_VOICES - 1);

    typedef enum logic [1:0] {
        IDLE       = 2'd0,
        LOOKUP     = 2'd1,
        WAIT_FRAME = 2'd2,
        APPLY      = 2'd3
    } state_t;

    state_t                r_state;
    state_t                w_state_next;

    logic                  r_key_on;
    logic [PERIOD_W-1:0]   r_key_period;
    logic [IDX_W-1:0]      r_target;
    logic                  r_steal;

    logic [PERIOD_W-1:0]   r_period [NUM_VOICES];
    logic [IDX_W-1:0]      r_rank   [NUM_VOICES];
    logic [NUM_VOICES-1:0] r_active;

    logic                  w_accept;
    logic                  w_match_found;
    logic [IDX_W-1:0]      w_match_idx;
    logic                  w_free_found;
    logic [IDX_W-1:0]      w_free_idx;
    logic [IDX_W-1:0]      w_oldest_idx;
    logic [IDX_W-1:0]      w_sel_idx;
    logic                  w_sel_steal;
    logic                  w_drop;

    // Voice search. Scanning from the top down and overwriting leaves the
    // lowest matching index in each result.
    always_comb begin
        w_match_found = 1'b0;
        w_match_idx   = '0;
        w_free_found  = 1'b0;
        w_free_idx    = '0;
        w_oldest_idx  = '0;
        for (int i = NUM_VOICES - 1; i >= 0; i--) begin
            if (r_active[i] && (r_period[i] == r_key_period)) begin
                w_match_found = 1'b1;
                w_match_idx   = IDX_W'(i);
            end
            if (!r_active[i]) begin
                w_free_found = 1'b1;
                w_free_idx   = IDX_W'(i);
            end
            if (r_rank[i] == OLDEST_RANK) begin
                w_oldest_idx = IDX_W'(i);
            end
        end
    end

    // Target selection: retrigger beats a free voice, which beats stealing.
    always_comb begin
        w_sel_idx   = '0;
        w_sel_steal = 1'b0;
        w_drop      = 1'b0;
        if (r_key_on) begin
            if (r_key_period == '0) begin
                w_drop = 1'b1;
            end else if (w_match_found) begin
                w_sel_idx = w_match_idx;
            end else if (w_free_found) begin
                w_sel_idx = w_free_idx;
            end else begin
                w_sel_idx   = w_oldest_idx;
                w_sel_steal = 1'b1;
            end
        end else begin
            w_sel_idx = w_match_idx;
            w_drop    = !w_match_found;
        end
    end

    // Outputs are gated by RESET so an event caught mid-flight by reset emits nothing.
    always_comb begin
        w_state_next = r_state;
        KEY_READY    = 1'b0;
        VOICE_EN     = '0;
        STOLE        = 1'b0;
        case (r_state)
            IDLE: begin
                KEY_READY = !RESET;
                if (KEY_VALID && !RESET) begin
                    w_state_next = LOOKUP;
                end
            end
            LOOKUP: begin
                w_state_next = w_drop ? IDLE : WAIT_FRAME;
            end
            WAIT_FRAME: begin
                if (frame_sig) begin
                    w_state_next = APPLY;
                end
            end
            APPLY: begin
                w_state_next = IDLE;
                if (r_key_on && !RESET) begin
                    VOICE_EN[r_target] = 1'b1;
                    STOLE              = r_steal;
                end
            end
            default: w_state_next = IDLE;
        endcase
    end

    assign w_accept = KEY_VALID && KEY_READY;

    always_ff @(posedge BIT_CLK) begin
        if (RESET) begin
            r_state      <= IDLE;
            r_key_on     <= 1'b0;
            r_key_period <= '0;
            r_target     <= '0;
            r_steal      <= 1'b0;
            r_active     <= '0;
            for (int i = 0; i < NUM_VOICES; i++) begin
                r_period[i] <= PERIOD_W'(RST_PERIOD);
                r_rank[i]   <= IDX_W'(i);
            end
        end else begin
            r_state <= w_state_next;
            if (w_accept) begin
                r_key_on     <= KEY_ON;
                r_key_period <= KEY_PERIOD;
            end
            if (r_state == LOOKUP) begin
                r_target <= w_sel_idx;
                r_steal  <= w_sel_steal;
            end
            if (r_state == APPLY) begin
                if (r_key_on) begin
                    r_period[r_target] <= r_key_period;
                    r_active[r_target] <= 1'b1;
                    // Move target to most-recent; everything younger ages by one.
                    for (int i = 0; i < NUM_VOICES; i++) begin
                        if (IDX_W'(i) == r_target) begin
                            r_rank[i] <= '0;
                        end else if (r_rank[i] < r_rank[r_target]) begin
                            r_rank[i] <= r_rank[i] + 1'b1;
                        end
                    end
                end else begin
                    r_active[r_target] <= 1'b0;
                end
            end
        end
    end

    always_comb begin
        VOICE_PERIOD = '0;
        for (int i = 0; i < NUM_VOICES; i++) begin
            VOICE_PERIOD[i*PERIOD_W +: PERIOD_W] = r_period[i];
        end
    end

    assign VOICE_ACTIVE = r_active;

endmodule

// File: tb/tb_voice_allocator.sv
// tb/tb_voice_allocator.sv - directed self-checking bench for voice_allocator
module tb_voice_allocator;

    logic        BIT_CLK = 1'b0;
    logic        RESET;
    logic        frame_sig;
    logic        KEY_VALID;
    logic        KEY_READY;
    logic        KEY_ON;
    logic [6:0]  KEY_PERIOD;
    logic [27:0] VOICE_PERIOD;
    logic [3:0]  VOICE_EN;
    logic [3:0]  VOICE_ACTIVE;
    logic        STOLE;

    int checks = 0;
    int errors = 0;

    int         ev_en_cyc;
    int         ev_en_cnt;
    int         ev_stole_cnt;
    logic [3:0] ev_en_mask;
    logic       ev_ready_c2;

    voice_allocator #(
        .NUM_VOICES (4),
        .PERIOD_W   (7),
        .RST_PERIOD (48)
    ) dut (
        .BIT_CLK      (BIT_CLK),
        .RESET        (RESET),
        .frame_sig    (frame_sig),
        .KEY_VALID    (KEY_VALID),
        .KEY_READY    (KEY_READY),
        .KEY_ON       (KEY_ON),
        .KEY_PERIOD   (KEY_PERIOD),
        .VOICE_PERIOD (VOICE_PERIOD),
        .VOICE_EN     (VOICE_EN),
        .VOICE_ACTIVE (VOICE_ACTIVE),
        .STOLE        (STOLE)
    );

    always #5 BIT_CLK = ~BIT_CLK;

    initial begin
        #500000;
        $display("FAIL watchdog expired got timeout want finish");
        $fatal(1);
    end

    task automatic do_reset();
        RESET      = 1'b1;
        KEY_VALID  = 1'b0;
        KEY_ON     = 1'b0;
        KEY_PERIOD = '0;
        frame_sig  = 1'b0;
        repeat (3) @(posedge BIT_CLK);
        #1 RESET = 1'b0;
    endtask

    // Sends one event and watches 10 cycles after accept; cycle 1 is LOOKUP.
    // frame_sig is pulsed on cycles fa and fb (0 = unused).
    task automatic run_event(input logic on, input logic [6:0] per, input int fa, input int fb);
        int waited;
        waited       = 0;
        ev_en_cyc    = 0;
        ev_en_cnt    = 0;
        ev_stole_cnt = 0;
        ev_en_mask   = '0;
        ev_ready_c2  = 1'b0;
        @(negedge BIT_CLK);
        while (!KEY_READY && waited < 20) begin
            @(negedge BIT_CLK);
            waited++;
        end
        checks++;
        if (KEY_READY !== 1'b1) begin
            errors++;
            $display("FAIL ready_wait got %b want 1", KEY_READY);
        end
        KEY_VALID  = 1'b1;
        KEY_ON     = on;
        KEY_PERIOD = per;
        @(posedge BIT_CLK);
        #1 KEY_VALID = 1'b0;
        for (int c = 1; c <= 10; c++) begin
            frame_sig = (c == fa) || (c == fb);
            @(negedge BIT_CLK);
            if (VOICE_EN !== 4'b0000) begin
                ev_en_cnt++;
                if (ev_en_cyc == 0) begin
                    ev_en_cyc  = c;
                    ev_en_mask = VOICE_EN;
                end
            end
            if (STOLE === 1'b1) ev_stole_cnt++;
            if (c == 2) ev_ready_c2 = KEY_READY;
            @(posedge BIT_CLK);
            #1;
        end
        frame_sig = 1'b0;
    endtask

    task automatic test_reset();
        RESET      = 1'b1;
        KEY_VALID  = 1'b0;
        KEY_ON     = 1'b0;
        KEY_PERIOD = '0;
        frame_sig  = 1'b0;
        repeat (2) @(posedge BIT_CLK);
        @(negedge BIT_CLK);
        checks++;
        if (KEY_READY !== 1'b0) begin errors++; $display("FAIL ready_in_reset got %b want 0", KEY_READY); end
        @(posedge BIT_CLK);
        #1 RESET = 1'b0;
        @(negedge BIT_CLK);
        checks++;
        if (VOICE_ACTIVE !== 4'b0000) begin errors++; $display("FAIL reset_active got %b want 0000", VOICE_ACTIVE); end
        checks++;
        if (VOICE_PERIOD !== {7'd48, 7'd48, 7'd48, 7'd48}) begin errors++; $display("FAIL reset_period got %h want %h", VOICE_PERIOD, {7'd48, 7'd48, 7'd48, 7'd48}); end
        checks++;
        if (KEY_READY !== 1'b1) begin errors++; $display("FAIL reset_ready got %b want 1", KEY_READY); end
        checks++;
        if (VOICE_EN !== 4'b0000 || STOLE !== 1'b0) begin errors++; $display("FAIL reset_en_stole got %b/%b want 0000/0", VOICE_EN, STOLE); end
    endtask

    task automatic test_single_note();
        do_reset();
        run_event(1'b1, 7'd40, 2, 0);
        checks++;
        if (ev_en_cyc !== 3) begin errors++; $display("FAIL single_latency got %0d want 3", ev_en_cyc); end
        checks++;
        if (ev_en_mask !== 4'b0001 || ev_en_cnt !== 1) begin errors++; $display("FAIL single_en got %b x%0d want 0001 x1", ev_en_mask, ev_en_cnt); end
        checks++;
        if (VOICE_PERIOD[6:0] !== 7'd40) begin errors++; $display("FAIL single_period got %0d want 40", VOICE_PERIOD[6:0]); end
        checks++;
        if (VOICE_ACTIVE !== 4'b0001 || ev_stole_cnt !== 0) begin errors++; $display("FAIL single_active got %b stole %0d want 0001 stole 0", VOICE_ACTIVE, ev_stole_cnt); end
    endtask

    task automatic test_steal_and_note_off();
        logic [6:0] notes [4];
        logic [3:0] masks [4];
        notes = '{7'd40, 7'd30, 7'd20, 7'd10};
        masks = '{4'b0001, 4'b0010, 4'b0100, 4'b1000};
        do_reset();
        for (int k = 0; k < 4; k++) begin
            run_event(1'b1, notes[k], 2, 0);
            checks++;
            if (ev_en_mask !== masks[k] || ev_stole_cnt !== 0) begin errors++; $display("FAIL fill_%0d got %b stole %0d want %b stole 0", k, ev_en_mask, ev_stole_cnt, masks[k]); end
        end
        run_event(1'b1, 7'd50, 2, 0);
        checks++;
        if (ev_en_mask !== 4'b0001 || ev_stole_cnt !== 1) begin errors++; $display("FAIL steal_en got %b stole %0d want 0001 stole 1", ev_en_mask, ev_stole_cnt); end
        checks++;
        if (VOICE_PERIOD !== {7'd10, 7'd20, 7'd30, 7'd50} || VOICE_ACTIVE !== 4'b1111) begin errors++; $display("FAIL steal_state got %h/%b want %h/1111", VOICE_PERIOD, VOICE_ACTIVE, {7'd10, 7'd20, 7'd30, 7'd50}); end

        run_event(1'b0, 7'd30, 2, 0);
        checks++;
        if (ev_en_cnt !== 0 || ev_stole_cnt !== 0) begin errors++; $display("FAIL off_pulses got en %0d stole %0d want 0 0", ev_en_cnt, ev_stole_cnt); end
        checks++;
        if (VOICE_ACTIVE !== 4'b1101 || VOICE_PERIOD !== {7'd10, 7'd20, 7'd30, 7'd50}) begin errors++; $display("FAIL off_state got %b/%h want 1101/%h", VOICE_ACTIVE, VOICE_PERIOD, {7'd10, 7'd20, 7'd30, 7'd50}); end

        run_event(1'b0, 7'd99, 0, 0);
        checks++;
        if (ev_ready_c2 !== 1'b1) begin errors++; $display("FAIL drop_ready got %b want 1", ev_ready_c2); end
        checks++;
        if (ev_en_cnt !== 0 || VOICE_ACTIVE !== 4'b1101 || VOICE_PERIOD !== {7'd10, 7'd20, 7'd30, 7'd50}) begin errors++; $display("FAIL drop_state got en %0d %b/%h want 0 1101", ev_en_cnt, VOICE_ACTIVE, VOICE_PERIOD); end
    endtask

    task automatic test_retrigger_lru();
        logic [6:0] notes [4];
        notes = '{7'd40, 7'd30, 7'd20, 7'd10};
        do_reset();
        for (int k = 0; k < 4; k++) run_event(1'b1, notes[k], 2, 0);
        run_event(1'b1, 7'd40, 2, 0);
        checks++;
        if (ev_en_mask !== 4'b0001 || ev_stole_cnt !== 0) begin errors++; $display("FAIL retrig_en got %b stole %0d want 0001 stole 0", ev_en_mask, ev_stole_cnt); end
        run_event(1'b1, 7'd60, 2, 0);
        checks++;
        if (ev_en_mask !== 4'b0010 || ev_stole_cnt !== 1) begin errors++; $display("FAIL lru_steal got %b stole %0d want 0010 stole 1", ev_en_mask, ev_stole_cnt); end
        checks++;
        if (VOICE_PERIOD !== {7'd10, 7'd20, 7'd60, 7'd40}) begin errors++; $display("FAIL lru_period got %h want %h", VOICE_PERIOD, {7'd10, 7'd20, 7'd60, 7'd40}); end
    endtask

    task automatic test_frame_boundary();
        do_reset();
        // frame_sig during LOOKUP must be ignored; the next one at cycle 4 applies.
        run_event(1'b1, 7'd40, 1, 4);
        checks++;
        if (ev_en_cyc !== 5 || ev_en_cnt !== 1) begin errors++; $display("FAIL lookup_frame got cyc %0d x%0d want cyc 5 x1", ev_en_cyc, ev_en_cnt); end
        run_event(1'b1, 7'd0, 2, 0);
        checks++;
        if (ev_en_cnt !== 0 || ev_ready_c2 !== 1'b1 || VOICE_ACTIVE !== 4'b0001) begin errors++; $display("FAIL zero_drop got en %0d ready %b act %b want 0 1 0001", ev_en_cnt, ev_ready_c2, VOICE_ACTIVE); end
    endtask

    task automatic test_reset_abort();
        int en_seen;
        int waited;
        en_seen = 0;
        waited  = 0;
        do_reset();
        @(negedge BIT_CLK);
        while (!KEY_READY && waited < 20) begin
            @(negedge BIT_CLK);
            waited++;
        end
        KEY_VALID  = 1'b1;
        KEY_ON     = 1'b1;
        KEY_PERIOD = 7'd25;
        @(posedge BIT_CLK);
        #1 KEY_VALID = 1'b0;
        @(posedge BIT_CLK);
        #1;
        RESET     = 1'b1;
        frame_sig = 1'b1;
        for (int c = 0; c < 6; c++) begin
            @(negedge BIT_CLK);
            if (VOICE_EN !== 4'b0000 || STOLE !== 1'b0) en_seen++;
            @(posedge BIT_CLK);
            #1;
            if (c == 1) begin
                RESET     = 1'b0;
                frame_sig = 1'b0;
            end
        end
        @(negedge BIT_CLK);
        checks++;
        if (en_seen !== 0) begin errors++; $display("FAIL abort_pulses got %0d want 0", en_seen); end
        checks++;
        if (VOICE_ACTIVE !== 4'b0000 || VOICE_PERIOD !== {7'd48, 7'd48, 7'd48, 7'd48} || KEY_READY !== 1'b1) begin errors++; $display("FAIL abort_state got %b/%h/%b want 0000/reset/1", VOICE_ACTIVE, VOICE_PERIOD, KEY_READY); end
    endtask

    initial begin
        test_reset();
        test_single_note();
        test_steal_and_note_off();
        test_retrigger_lru();
        test_frame_boundary();
        test_reset_abort();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
